product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
Downstream stage of the 4x4 unsigned multiplier array. It consumes the 8-bit products over a valid/ready handshake and sums a programmed number of them (a dot-product / MAC tail). It returns the registered sum plus an overflow flag over a second valid/ready handshake. Used wherever multiplier results must be reduced over several beats before leaving the datapath.

Parameters:
PROD_W, 8, width of incoming product (fixed by upstream 4x4 array)
ACC_W, 12, accumulator/result width; must be >= PROD_W
MAX_LEN, 16, maximum beats per accumulation
CNT_W, $clog2(MAX_LEN+1), width of length/beat counter (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin new accumulation (honoured only in IDLE)
cfg_len  in  CNT_W  number of products to sum, sampled when start is accepted
in_valid  in  1  in_prod valid
in_ready  out  1  block accepts a product this cycle
in_prod  in  PROD_W  unsigned product from multiplier stage
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_acc  out  ACC_W  accumulated sum
out_ovf  out  1  sticky overflow seen during this accumulation
busy  out  1  state != IDLE

Behaviour:
- Single clock domain: clk. Reset: rst is asynchronous and active-high.
- Reset (async, any state, including mid-accumulation): state=IDLE; acc, beat count, out_acc, out_ovf all 0; out_valid=0, in_ready=0, busy=0. Any partial sum is discarded.
- FSM states: IDLE, ACCUM, DONE. All outputs are decoded from registers; there is no combinational path from in_valid or out_ready to any output.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> latch len=min(cfg_len, MAX_LEN), clear acc/ovf/count.
  - If len==0 -> DONE next cycle with out_acc=0, out_ovf=0.
  - Otherwise -> ACCUM.
- ACCUM:
  - in_ready=1. A beat is a cycle with in_valid&in_ready.
  - On a beat: sum={1'b0,acc}+zero-extend(in_prod); count++.
  - If sum[ACC_W]=1 -> ovf<=1 (sticky); acc update per the optional feature.
  - Cycles without in_valid change nothing.
  - On the beat where count==len-1 -> DONE.
  - out_acc/out_ovf are loaded with the final value, and out_valid=1, in the cycle after the last beat (latency 1).
- DONE:
  - in_ready=0. out_valid=1; out_acc and out_ovf are held stable until out_valid&out_ready, then -> IDLE.
  - start is ignored in ACCUM and DONE, including a start in the same cycle as the DONE handshake; it must be re-asserted in IDLE.
- out_acc/out_ovf keep their last value in IDLE (not cleared until the next start).
- busy=1 in ACCUM and DONE.

Optional Feature:
PRODUCT_ACC_SATURATE_EN
- Defined: on overflow, acc clamps to {ACC_W{1'b1}} and stays clamped for the rest of the accumulation.
- Undefined: acc wraps modulo 2^ACC_W.
- out_ovf behaviour is identical in both builds.

Decomposition:
- Shared package product_acc_pkg:
  - state enum (IDLE/ACCUM/DONE)
  - PROD_W constant
  - default ACC_W / MAX_LEN constants
- One natural sub-module, acc_sat_adder: combinational ACC_W+PROD_W adder producing next acc and the overflow bit, with the PRODUCT_ACC_SATURATE_EN clamp inside. FSM and handshake stay in the top module.

Test Plan:
- cfg_len=4, start, four beats of in_prod=225 back-to-back -> out_valid rises 1 cycle after 4th beat, out_acc=900, out_ovf=0; out_ready=1 -> IDLE, busy=0.
- cfg_len=3, products 1,2,3 with in_valid bubbles (valid low 2 cycles between beats) -> only handshaked beats counted, out_acc=6.
- cfg_len=0 start -> DONE next cycle, out_acc=0, out_ovf=0, no in_ready pulse; also cfg_len=20 -> exactly 16 beats accepted.
- Backpressure: result ready, out_ready low 5 cycles with start pulsed -> out_acc/out_ovf stable, in_ready=0, start ignored; out_ready=1 -> IDLE.
- ACC_W=10, cfg_len=5, five beats of 225 (total 1125):
  - without macro -> out_acc=101, out_ovf=1
  - with PRODUCT_ACC_SATURATE_EN -> out_acc=1023, out_ovf=1
- rst asserted asynchronously after 2 of 4 beats -> outputs immediately 0, state IDLE; a subsequent len=2 run of 10,20 -> out_acc=30.

Source files
------------

// File: rtl/product_acc_pkg.sv
// Shared types and constants for the product accumulator (multiplier-array tail).
// Product width is fixed by the upstream 4x4 array; ACC_W/MAX_LEN are defaults only.
package product_acc_pkg;

  localparam int PROD_W      = 8;
  localparam int ACC_W_DEF   = 12;
  localparam int MAX_LEN_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/acc_sat_adder.sv
// Combinational accumulate step: acc + zero-extended product, with overflow bit.
// Build option PRODUCT_ACC_SATURATE_EN clamps the result on overflow instead of wrapping.
module acc_sat_adder
  import product_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o
);

  logic [ACC_W:0] sum;

  function automatic logic [ACC_W-1:0] limit_fn(input logic [ACC_W:0] s);
`ifdef PRODUCT_ACC_SATURATE_EN
    // An all-ones accumulator overflows again on any nonzero product, so it stays clamped.
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  assign sum   = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
  assign ovf_o = sum[ACC_W];
  assign acc_o = limit_fn(sum);

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of multiplier products over valid/ready and returns sum + sticky overflow.
// Optional build macro PRODUCT_ACC_SATURATE_EN selects clamping instead of wrapping (see acc_sat_adder).
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int   ACC_W   = ACC_W_DEF,
  parameter int   MAX_LEN = MAX_LEN_DEF,
  localparam int  CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   len_q;
  logic [ACC_W-1:0]   out_acc_q;
  logic               out_ovf_q;

  logic [ACC_W-1:0]   acc_d;
  logic               carry_d;
  logic               ovf_d;
  logic [CNT_W-1:0]   len_d;
  logic               beat;
  logic               last_beat;

  acc_sat_adder #(
    .ACC_W (ACC_W)
  ) u_adder (
    .acc_i  (acc_q),
    .prod_i (in_prod),
    .acc_o  (acc_d),
    .ovf_o  (carry_d)
  );

  assign len_d     = (cfg_len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : cfg_len;
  assign ovf_d     = ovf_q | carry_d;
  assign beat      = in_valid && (state_q == ACCUM);
  assign last_beat = (cnt_q == len_q - CNT_W'(1));

  // Handshake outputs are decoded from the state register only, never from in_valid/out_ready.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      out_acc_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q     <= len_d;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            out_acc_q <= '0;
            out_ovf_q <= 1'b0;
            state_q   <= (len_d == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat) begin
              out_acc_q <= acc_d;
              out_ovf_q <= ovf_d;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 12-bit and a 10-bit instance share all inputs.
module tb_product_accumulator;

  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] cfg_len;
  logic             in_valid;
  logic [7:0]       in_prod;
  logic             out_ready;

  logic             in_ready, out_valid, out_ovf, busy;
  logic [11:0]      out_acc;
  logic             in_ready10, out_valid10, out_ovf10, busy10;
  logic [9:0]       out_acc10;

  int errors = 0;
  int checks = 0;

  product_accumulator #(.ACC_W(12), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_ovf(out_ovf), .busy(busy)
  );

  product_accumulator #(.ACC_W(10), .MAX_LEN(16)) dut10 (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready10), .in_prod(in_prod),
    .out_valid(out_valid10), .out_ready(out_ready), .out_acc(out_acc10),
    .out_ovf(out_ovf10), .busy(busy10)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [CNT_W-1:0] len);
    cfg_len = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic beat(input logic [7:0] p);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_prod  = p;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("beat_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int acc_cnt;
    logic [31:0] exp10;
    rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_acc", {20'd0, out_acc}, 32'd0);
    rst = 1'b0;
    tick();

    // Four back-to-back beats of 225
    kick(5'd4);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b1; in_prod = 8'd225;
    for (int i = 0; i < 4; i++) begin
      chk("t1_rdy", {31'd0, in_ready}, 32'd1);
      chk("t1_noval", {31'd0, out_valid}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_acc", {20'd0, out_acc}, 32'd900);
    chk("t1_ovf", {31'd0, out_ovf}, 32'd0);
    chk("t1_rdy_off", {31'd0, in_ready}, 32'd0);
    drain();
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_hold", {20'd0, out_acc}, 32'd900);

    // Beats separated by valid bubbles
    kick(5'd3);
    for (int i = 1; i <= 3; i++) begin
      beat(8'(i));
      if (i < 3) begin
        tick();
        tick();
        chk("t2_pending", {31'd0, out_valid}, 32'd0);
      end
    end
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_acc", {20'd0, out_acc}, 32'd6);
    drain();

    // Zero length finishes without accepting anything
    kick(5'd0);
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_rdy", {31'd0, in_ready}, 32'd0);
    chk("t3_acc", {20'd0, out_acc}, 32'd0);
    chk("t3_ovf", {31'd0, out_ovf}, 32'd0);
    drain();

    // Oversized length is clamped to 16 beats
    kick(5'd20);
    acc_cnt = 0;
    in_valid = 1'b1; in_prod = 8'd100;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      if (in_ready) acc_cnt++;
      tick();
    end
    in_valid = 1'b0;
    chk("t3_beats", acc_cnt, 32'd16);
    chk("t3_valid16", {31'd0, out_valid}, 32'd1);
    chk("t3_acc16", {20'd0, out_acc}, 32'd1600);
    drain();

    // Backpressure on the result with start held high
    kick(5'd1);
    beat(8'd7);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_rdy", {31'd0, in_ready}, 32'd0);
      chk("t4_acc", {20'd0, out_acc}, 32'd7);
    end
    out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("t4_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("t4_stay", {31'd0, busy}, 32'd0);

    // Overflow on the 10-bit instance: 5 x 225 = 1125
    kick(5'd5);
    for (int i = 0; i < 5; i++) beat(8'd225);
`ifdef PRODUCT_ACC_SATURATE_EN
    exp10 = 32'd1023;
`else
    exp10 = 32'd101;
`endif
    chk("t5_acc10", {22'd0, out_acc10}, exp10);
    chk("t5_ovf10", {31'd0, out_ovf10}, 32'd1);
    chk("t5_acc12", {20'd0, out_acc}, 32'd1125);
    chk("t5_ovf12", {31'd0, out_ovf}, 32'd0);
    drain();

    // Asynchronous reset mid-accumulation
    kick(5'd4);
    beat(8'd50);
    beat(8'd50);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_rdy", {31'd0, in_ready}, 32'd0);
    chk("t6_ovf10", {31'd0, out_ovf10}, 32'd0);
    chk("t6_acc", {20'd0, out_acc}, 32'd0);
    #3 rst = 1'b0;
    tick();
    kick(5'd2);
    beat(8'd10);
    beat(8'd20);
    chk("t6_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_sum", {20'd0, out_acc}, 32'd30);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
